stream_traffic_gen: RTL and testbench
=====================================

// Module: stream_traffic_gen
// PURPOSE
//  Initiator end of the team's val/rdy stream protocol. Sends a programmed arithmetic
//  sequence of words on an outbound stream to a stream DUT (e.g. the +1 stream adder).
//  Accepts the DUT's returned stream and checks each word against sent_word + EXP_OFFSET.
//  Counts mismatches and reports done. Used as the on-chip traffic source/checker in full-chip demos.
// PARAMETERS
//  DATA_W      32  stream data width
//  CNT_W       16  width of word count, index and error counters
//  EXP_OFFSET  1   value added to each sent word to form the expected returned word (mod 2^DATA_W)
//  MAX_OUT     1   max words sent but not yet returned (1..2^CNT_W-1)
// PORTS
//  clk              in   1       single clock
//  reset_n          in   1       asynchronous, active-low reset
//  start            in   1       1-cycle pulse; begins a run (honoured only in IDLE/DONE)
//  abort            in   1       ends a run immediately; returns to IDLE
//  cfg_seed         in   DATA_W  first word sent; sampled on accepted start
//  cfg_stride       in   DATA_W  increment between sent words; sampled on accepted start
//  cfg_count        in   CNT_W   number of words to send/check; sampled on accepted start
//  o_stream_val     out  1       outbound word valid
//  o_stream_rdy     in   1       DUT accepts outbound word
//  o_stream_data    out  DATA_W  outbound word
//  i_stream_val     in   1       DUT return word valid
//  i_stream_rdy     out  1       this block accepts return word
//  i_stream_data    in   DATA_W  return word
//  busy             out  1       state == RUN
//  done             out  1       state == DONE
//  err_count        out  CNT_W   mismatches this run; saturates at all-ones
//  first_err_idx    out  CNT_W   rx index of first mismatch; valid when err_count != 0
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; all counters, err_count and first_err_idx = 0.
//    o_stream_data = 0; o_stream_val, i_stream_rdy, busy and done = 0 immediately.
//  - FSM IDLE/RUN/DONE:
//    - IDLE or DONE + start, cfg_count != 0 -> RUN. Latch cfg_*; tx_word=seed, rx_exp=seed+EXP_OFFSET.
//      tx_cnt, rx_cnt and err_count are cleared.
//    - IDLE or DONE + start, cfg_count == 0 -> DONE next cycle; err_count = 0.
//    - RUN: start is ignored. abort -> IDLE next cycle (abort wins over any transfer that cycle).
//    - RUN -> DONE on the clock edge of the rx transfer that makes rx_cnt == count.
//    - DONE is held until the next start.
//  - A transfer occurs when val & rdy are both high at the clock edge.
//  - Outbound: o_stream_val = RUN & tx_cnt < count & (tx_cnt - rx_cnt) < MAX_OUT.
//    o_stream_data = tx_word.
//    - Both are decoded from registers only; no combinational path from o_stream_rdy.
//    - On transfer: tx_word += stride (wraps mod 2^DATA_W); tx_cnt++.
//    - Once val is high, val and data stay stable until the transfer, an abort or reset.
//  - Return: i_stream_rdy = RUN & rx_cnt < tx_cnt (never accepts a word that was not sent).
//    - On transfer: i_stream_data != rx_exp -> err_count++ (saturating).
//      If it is the first mismatch, first_err_idx = rx_cnt.
//    - Then rx_exp += stride (wrap); rx_cnt++.
//  - Same-cycle tx and rx transfers are both applied; outstanding count is unchanged.
//  - Latency: first o_stream_val is the cycle after an accepted start. done is high the cycle after the last rx transfer.
//  - err_count and first_err_idx hold their values in DONE and IDLE until the next accepted start.
// TESTING
//  1. seed=5, stride=3, count=4, +1 adder DUT -> sends 5,8,11,14; receives 6,9,12,15.
//     Expect err_count=0, done=1; at most 1 word outstanding at any time.
//  2. seed=32'hFFFF_FFFE, stride=1, count=3 -> sends FFFFFFFE, FFFFFFFF, 0.
//     Expect 0 errors (expected FFFFFFFF, 0, 1).
//  3. Loopback DUT returning word+0, count=5, seed=0, stride=2 -> err_count=5, first_err_idx=0.
//     Same run with only the 3rd return word corrupted -> err_count=1, first_err_idx=2.
//  4. MAX_OUT=4, sink holds i_stream_val low -> exactly 4 words sent, then o_stream_val=0.
//     Release the sink -> all words flow; done after count returns.
//  5. Random o_stream_rdy stalls -> o_stream_data/val stable while stalled.
//     start pulse in RUN is ignored; cfg_count=0 start -> done next cycle, no traffic.
//  6. abort mid-run (after 2 of 6 words) -> IDLE next cycle, vals drop.
//     reset_n low mid-run -> outputs 0 immediately; a fresh start then runs cleanly.

Source files
------------

// File: rtl/stream_traffic_gen.sv
// stream_traffic_gen
//   Initiator end of the val/rdy stream protocol. Sends an arithmetic sequence
//   (seed, seed+stride, ...) on the outbound stream, accepts the returned stream
//   and checks each returned word against sent_word + EXP_OFFSET. Counts
//   mismatches (saturating) and remembers the rx index of the first one.
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, abort                 run control (start honoured in IDLE/DONE only)
//   cfg_seed/stride/count        run configuration, sampled on accepted start
//   o_stream_val/rdy/data        outbound stream (this block is the source)
//   i_stream_val/rdy/data        return stream (this block is the sink)
//   busy, done                   state == RUN, state == DONE
//   err_count, first_err_idx     mismatch count and index of first mismatch
module stream_traffic_gen #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EXP_OFFSET = 1,
  parameter int unsigned MAX_OUT    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [DATA_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              o_stream_val,
  input  logic              o_stream_rdy,
  output logic [DATA_W-1:0] o_stream_data,
  input  logic              i_stream_val,
  output logic              i_stream_rdy,
  input  logic [DATA_W-1:0] i_stream_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx
);

  localparam logic [CNT_W-1:0]  MaxOut    = CNT_W'(MAX_OUT);
  localparam logic [DATA_W-1:0] ExpOffset = DATA_W'(EXP_OFFSET);
  localparam logic [CNT_W-1:0]  ErrMax    = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_stride;
  logic [DATA_W-1:0] r_tx_word;
  logic [DATA_W-1:0] r_rx_exp;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [CNT_W-1:0]  r_err_count;
  logic [CNT_W-1:0]  r_first_err_idx;

  logic              w_run;
  logic [CNT_W-1:0]  w_outstanding;
  logic              w_tx_val;
  logic              w_rx_rdy;
  logic              w_tx_fire;
  logic              w_rx_fire;
  logic              w_mismatch;
  logic              w_last_rx;

  // Handshake outputs depend on registers only, never on the partner's rdy/val.
  assign w_run         = (r_state == StRun);
  assign w_outstanding = r_tx_cnt - r_rx_cnt;
  assign w_tx_val      = w_run && (r_tx_cnt < r_count) && (w_outstanding < MaxOut);
  assign w_rx_rdy      = w_run && (r_rx_cnt < r_tx_cnt);
  assign w_tx_fire     = w_tx_val && o_stream_rdy;
  assign w_rx_fire     = w_rx_rdy && i_stream_val;
  assign w_mismatch    = (i_stream_data != r_rx_exp);
  // rx_cnt < tx_cnt <= count whenever rdy is high, so the +1 cannot wrap.
  assign w_last_rx     = w_rx_fire && ((r_rx_cnt + CNT_W'(1)) == r_count);

  assign o_stream_val  = w_tx_val;
  assign o_stream_data = r_tx_word;
  assign i_stream_rdy  = w_rx_rdy;
  assign busy          = w_run;
  assign done          = (r_state == StDone);
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_stride        <= '0;
      r_tx_word       <= '0;
      r_rx_exp        <= '0;
      r_count         <= '0;
      r_tx_cnt        <= '0;
      r_rx_cnt        <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_tx_cnt        <= '0;
            r_rx_cnt        <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_count         <= cfg_count;
            r_stride        <= cfg_stride;
            r_tx_word       <= cfg_seed;
            r_rx_exp        <= cfg_seed + ExpOffset;
            r_state         <= (cfg_count == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          // Abort discards any transfer that happens in the same cycle.
          if (abort) begin
            r_state <= StIdle;
          end else begin
            if (w_tx_fire) begin
              r_tx_word <= r_tx_word + r_stride;
              r_tx_cnt  <= r_tx_cnt + CNT_W'(1);
            end
            if (w_rx_fire) begin
              if (w_mismatch) begin
                if (r_err_count == '0) begin
                  r_first_err_idx <= r_rx_cnt;
                end
                if (r_err_count != ErrMax) begin
                  r_err_count <= r_err_count + CNT_W'(1);
                end
              end
              r_rx_exp <= r_rx_exp + r_stride;
              r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            end
            if (w_last_rx) begin
              r_state <= StDone;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_traffic_gen.sv
module tb_stream_traffic_gen;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, abort, sel;
  logic [DW-1:0] cfg_seed, cfg_stride;
  logic [CW-1:0] cfg_count;
  logic          ordy, iv;
  logic [DW-1:0] id;

  logic          a_ov, a_ird, a_busy, a_done, b_ov, b_ird, b_busy, b_done;
  logic [DW-1:0] a_od, b_od;
  logic [CW-1:0] a_err, a_fidx, b_err, b_fidx;
  logic          start_a, start_b;

  logic          w_ov, w_ird, w_busy, w_done;
  logic [DW-1:0] w_od;
  logic [CW-1:0] w_err, w_fidx;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign w_ov    = sel ? b_ov   : a_ov;
  assign w_ird   = sel ? b_ird  : a_ird;
  assign w_busy  = sel ? b_busy : a_busy;
  assign w_done  = sel ? b_done : a_done;
  assign w_od    = sel ? b_od   : a_od;
  assign w_err   = sel ? b_err  : a_err;
  assign w_fidx  = sel ? b_fidx : a_fidx;

  stream_traffic_gen #(.DATA_W(DW), .CNT_W(CW), .EXP_OFFSET(1), .MAX_OUT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort),
    .cfg_seed(cfg_seed), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
    .o_stream_val(a_ov), .o_stream_rdy(ordy), .o_stream_data(a_od),
    .i_stream_val(iv), .i_stream_rdy(a_ird), .i_stream_data(id),
    .busy(a_busy), .done(a_done), .err_count(a_err), .first_err_idx(a_fidx)
  );

  stream_traffic_gen #(.DATA_W(DW), .CNT_W(CW), .EXP_OFFSET(1), .MAX_OUT(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort),
    .cfg_seed(cfg_seed), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
    .o_stream_val(b_ov), .o_stream_rdy(ordy), .o_stream_data(b_od),
    .i_stream_val(iv), .i_stream_rdy(b_ird), .i_stream_data(id),
    .busy(b_busy), .done(b_done), .err_count(b_err), .first_err_idx(b_fidx)
  );

  // Reference model: a run is described by counts of words sent/returned;
  // word k is seed + k*stride and must come back as that plus 1.
  bit            m_run, m_done;
  int unsigned   m_ntx, m_nrx, m_count, maxout;
  logic [DW-1:0] m_seed, m_stride;
  logic [CW-1:0] m_err, m_first;

  // Stand-in stream DUT: returns each accepted word plus dut_add, optionally corrupted.
  logic [DW-1:0] rq[$];
  int            dut_add, corrupt_idx;
  bit            sink_en, rnd_or, rnd_iv;
  bit            p_stall;
  logic [DW-1:0] p_data;

  int n_pass, n_total;

  typedef struct {
    logic [DW-1:0] seed;
    logic [DW-1:0] stride;
    logic [CW-1:0] count;
    bit            sel;
    bit            rnd;
    int            add;
    int            corrupt;
    logic [CW-1:0] exp_err;
    logic [CW-1:0] exp_first;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] word_at(input int unsigned k);
    return m_seed + m_stride * DW'(k);
  endfunction

  // One clock cycle: observe at negedge, update model for the coming edge,
  // then drive the next inputs just after the edge.
  task automatic step();
    bit tx_fire, rx_fire;
    logic [DW-1:0] w;
    @(negedge clk);
    chk("o_stream_val", 32'(w_ov),
        32'(m_run && (m_ntx < m_count) && ((m_ntx - m_nrx) < maxout)));
    chk("i_stream_rdy", 32'(w_ird), 32'(m_run && (m_nrx < m_ntx)));
    chk("busy", 32'(w_busy), 32'(m_run));
    chk("done", 32'(w_done), 32'(m_done));
    chk("err_count", 32'(w_err), 32'(m_err));
    if (m_err != '0) chk("first_err_idx", 32'(w_fidx), 32'(m_first));
    if (p_stall) begin
      chk("stall_val", 32'(w_ov), 32'd1);
      chk("stall_data", w_od, p_data);
    end
    tx_fire = w_ov && ordy && !abort;
    rx_fire = iv && w_ird && !abort;
    p_stall = w_ov && !ordy && !abort;
    p_data  = w_od;
    if (m_run && abort) begin
      m_run  = 0;
      m_done = 0;
      rq.delete();
    end else if (m_run) begin
      if (tx_fire) begin
        chk("tx_data", w_od, word_at(m_ntx));
        w = w_od + DW'(dut_add);
        if (int'(m_ntx) == corrupt_idx) w = w ^ 32'h0000_0100;
        rq.push_back(w);
        m_ntx++;
      end
      if (rx_fire) begin
        if (id !== word_at(m_nrx) + 32'd1) begin
          if (m_err == '0) m_first = CW'(m_nrx);
          if (m_err != '1) m_err = m_err + 1'b1;
        end
        void'(rq.pop_front());
        m_nrx++;
      end
      if (m_nrx == m_count) begin
        m_run  = 0;
        m_done = 1;
      end
    end else if (start) begin
      m_err   = '0;
      m_first = '0;
      if (cfg_count == '0) begin
        m_done = 1;
      end else begin
        m_run    = 1;
        m_done   = 0;
        m_seed   = cfg_seed;
        m_stride = cfg_stride;
        m_count  = cfg_count;
        m_ntx    = 0;
        m_nrx    = 0;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    ordy  = rnd_or ? 1'($urandom_range(0, 1)) : 1'b1;
    iv    = sink_en && (rq.size() > 0) && (rnd_iv ? ($urandom_range(0, 1) == 1) : 1'b1);
    id    = (rq.size() > 0) ? rq[0] : '0;
  endtask

  task automatic model_clear();
    m_run = 0; m_done = 0; m_ntx = 0; m_nrx = 0; m_count = 0;
    m_err = '0; m_first = '0; p_stall = 0;
    rq.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; ordy = 1'b0; iv = 1'b0; id = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !m_done && m_run; i++) step();
    if (m_run) begin
      chk("run_timeout", 32'(w_done), 32'd1);
      abort = 1'b1;
      step();
    end
  endtask

  task automatic begin_run(input logic [DW-1:0] seed, input logic [DW-1:0] stride,
                           input logic [CW-1:0] count);
    cfg_seed   = seed;
    cfg_stride = stride;
    cfg_count  = count;
    start      = 1'b1;
    step();
  endtask

  task automatic run_row(input vec_t v);
    if (v.sel != sel) begin
      sel = v.sel;
      do_reset();
    end
    maxout      = sel ? 4 : 1;
    dut_add     = v.add;
    corrupt_idx = v.corrupt;
    rnd_or      = v.rnd;
    rnd_iv      = v.rnd;
    sink_en     = 1;
    begin_run(v.seed, v.stride, v.count);
    wait_done();
    chk("row_done", 32'(w_done), 32'd1);
    chk("row_err", 32'(w_err), 32'(v.exp_err));
    if (v.exp_err != '0) chk("row_first", 32'(w_fidx), 32'(v.exp_first));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    sel = 1'b0; maxout = 1; dut_add = 1; corrupt_idx = -1;
    sink_en = 1; rnd_or = 0; rnd_iv = 0;
    cfg_seed = '0; cfg_stride = '0; cfg_count = '0;

    //            seed          stride      cnt  sel rnd add corr err first
    vecs[0] = '{32'd5,        32'd3,      16'd4,  1'b0, 1'b0, 1, -1, 16'd0, 16'd0};
    vecs[1] = '{32'hFFFF_FFFE, 32'd1,     16'd3,  1'b0, 1'b0, 1, -1, 16'd0, 16'd0};
    vecs[2] = '{32'd0,        32'd2,      16'd5,  1'b0, 1'b0, 0, -1, 16'd5, 16'd0};
    vecs[3] = '{32'd0,        32'd2,      16'd5,  1'b0, 1'b0, 1,  2, 16'd1, 16'd2};
    vecs[4] = '{$urandom,     $urandom,   16'd20, 1'b0, 1'b1, 1, -1, 16'd0, 16'd0};
    vecs[5] = '{$urandom,     $urandom,   16'd30, 1'b1, 1'b1, 1, -1, 16'd0, 16'd0};
    vecs[6] = '{$urandom,     $urandom,   16'd9,  1'b1, 1'b1, 0, -1, 16'd9, 16'd0};
    vecs[7] = '{$urandom,     $urandom,   16'd12, 1'b1, 1'b1, 1,  7, 16'd1, 16'd7};

    do_reset();
    chk("rst_val", 32'(a_ov), 32'd0);
    chk("rst_data", a_od, 32'd0);
    chk("rst_rdy", 32'(a_ird), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_fidx", 32'(a_fidx), 32'd0);
    chk("rst_val4", 32'(b_ov), 32'd0);

    for (int i = 0; i < 5; i++) run_row(vecs[i]);

    // start pulse while running must not restart the run
    dut_add = 0; corrupt_idx = -1; rnd_or = 1; rnd_iv = 1; sink_en = 1;
    begin_run(32'd100, 32'd7, 16'd6);
    repeat (3) step();
    cfg_seed = 32'hDEAD_0000; cfg_count = 16'd2; start = 1'b1;
    step();
    wait_done();
    chk("ign_start_err", 32'(w_err), 32'd6);
    chk("ign_start_first", 32'(w_fidx), 32'd0);

    // zero-length run: done next cycle, errors cleared, no traffic
    rnd_or = 0; rnd_iv = 0;
    begin_run(32'd9, 32'd9, 16'd0);
    chk("cnt0_done", 32'(w_done), 32'd1);
    chk("cnt0_err", 32'(w_err), 32'd0);
    repeat (4) step();
    chk("cnt0_noval", 32'(w_ov), 32'd0);

    // abort after two words
    dut_add = 1;
    begin_run(32'd50, 32'd1, 16'd6);
    for (int i = 0; i < 100 && m_ntx < 2; i++) step();
    chk("abort_sent", m_ntx, 32'd2);
    abort = 1'b1;
    step();
    chk("abort_busy", 32'(w_busy), 32'd0);
    chk("abort_done", 32'(w_done), 32'd0);
    chk("abort_val", 32'(w_ov), 32'd0);
    chk("abort_rdy", 32'(w_ird), 32'd0);
    repeat (3) step();

    // asynchronous reset in the middle of an erroring run
    dut_add = 0;
    begin_run(32'd1, 32'd1, 16'd6);
    repeat (6) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_val", 32'(w_ov), 32'd0);
    chk("arst_data", w_od, 32'd0);
    chk("arst_rdy", 32'(w_ird), 32'd0);
    chk("arst_busy", 32'(w_busy), 32'd0);
    chk("arst_done", 32'(w_done), 32'd0);
    chk("arst_err", 32'(w_err), 32'd0);
    do_reset();
    run_row(vecs[0]);

    for (int i = 5; i < 8; i++) run_row(vecs[i]);

    // MAX_OUT=4 with a blocked return path
    dut_add = 1; corrupt_idx = -1; rnd_or = 0; rnd_iv = 0; sink_en = 0;
    begin_run(32'd1000, 32'd10, 16'd8);
    repeat (10) step();
    chk("maxout_sent", m_ntx, 32'd4);
    chk("maxout_val", 32'(w_ov), 32'd0);
    sink_en = 1;
    wait_done();
    chk("maxout_done", 32'(w_done), 32'd1);
    chk("maxout_err", 32'(w_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
